jedro_1_iter_shifter: RTL and testbench
=======================================

Name: jedro_1_iter_shifter

Overview:
- Parametrised multi-cycle shift unit for the jedro_1 core. It executes SLL/SRL/SRA (and the immediate forms) by iterating STEP_BITS positions per cycle, which trades latency for area against a full barrel shifter.
- It sits beside the ALU in the execute stage.
- It uses valid/ready handshakes on input and output, so the pipeline stalls on it cleanly.

Parameters:
- DATA_WIDTH, 32, operand/result width; power of two, >= 8.
- STEP_BITS, 1, max bit positions shifted per cycle; 1..DATA_WIDTH.
- SHAMT_W, $clog2(DATA_WIDTH), localparam: shift-amount width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  unit can accept a request.
- op_i  in  2  2'b00 SLL, 2'b01 SRL, 2'b11 SRA, 2'b10 illegal.
- operand_i  in  DATA_WIDTH  value to shift.
- shamt_i  in  SHAMT_W  shift amount (unsigned).
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer takes result.
- result_o  out  DATA_WIDTH  shifted value.
- err_o  out  1  illegal op flag; qualified by out_valid_o.
- busy_o  out  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_i high at a clock edge):
  - state goes to IDLE.
  - out_valid_o=0, result_o=0, err_o=0, busy_o=0.
  - Internal operand register, op register and remaining counter are cleared.
  - in_ready_o=0 while rst_i is high.
  - Reset overrides any in-flight operation; the aborted operation emits no result.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready_o = 1.
  - The unit accepts a request when in_valid_i && in_ready_o; it latches op_i, operand_i and shanimt_i into remaining.
  - If op_i==2'b10, next state is DONE with result 0 and err_o=1.
  - If shamt_i==0, next state is DONE with result = operand.
  - Otherwise next state is SHIFT.
- SHIFT:
  - Each cycle: k = min(STEP_BITS, remaining); remaining -= k.
  - SLL shifts the register left by k, filling with 0.
  - SRL shifts the register right by k, filling with 0.
  - SRA shifts the register right by k, filling with the operand's original MSB.
  - The unit goes to DONE in the cycle where remaining becomes 0.
  - in_ready_o = 0.
- DONE:
  - out_valid_o = 1; result_o and err_o are held stable until the handshake.
  - On out_valid_o && out_ready_i, next state is IDLE and out_valid_o drops next cycle.
  - New requests are not accepted in DONE; in_valid_i is ignored. The next accept is possible one cycle after the output handshake.
- Latency from the accept edge to out_valid_o high: 1 + ceil(shamt/STEP_BITS) cycles.
  - Illegal op and shamt==0 both take 1 cycle.
  - STEP_BITS == DATA_WIDTH gives a fixed 2-cycle latency for all nonzero shamt.
- Outputs:
  - result_o is registered and equals 0 outside DONE.
  - err_o is 0 outside DONE.
  - busy_o = (state != IDLE).
- Arithmetic:
  - Result is bit-exact with the RV32I definition: x << shamt, x >> shamt (logical), $signed(x) >>> shamt.
  - shamt uses SHAMT_W bits only; higher instruction bits are the decoder's responsibility.
  - The sign bit is latched at accept and does not change during iteration.
- Input stability: operand_i, op_i and shamt_i are don't-care after the accept cycle.
- Reset and accept in the same cycle: reset wins and the request is dropped.

Test Plan:
- Basic SLL, STEP_BITS=1: accept SLL op=1 shamt=6 -> out_valid_o exactly 7 cycles after accept, result_o=32'h0000_0040, err_o=0. Then chain shamt 1,2,3 on results starting from 1 -> final 32'd64.
- Right shifts, STEP_BITS=4: SRA 32'h8000_0000 shamt=31 -> 32'hFFFF_FFFF after 9 cycles. SRL same operand -> 32'h0000_0001 after 9 cycles. SRA 32'h7000_0000 shamt=4 -> 32'h0700_0000 after 2 cycles.
- Zero shift and illegal op:
  - SRL 32'hDEAD_BEEF shamt=0 -> result 32'hDEAD_BEEF, valid 1 cycle after accept.
  - op=2'b10 -> err_o=1, result_o=0, valid after 1 cycle.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE while driving in_valid_i=1 with new data.
  - Required: result_o stays constant, in_ready_o=0, no new accept.
  - Release out_ready_i -> IDLE next cycle, accept the following cycle.
- Reset mid-operation: assert rst_i during SHIFT of SLL shamt=20 (STEP_BITS=1).
  - Next cycle: state IDLE, out_valid_o=0, busy_o=0, result_o=0.
  - in_ready_o=1 the cycle after rst_i deasserts; no stale result appears.
- Randomised sweep: all ops x shamt 0..31 x random operands, with STEP_BITS in {1,3,8,32}.
  - Required: results match the reference model and latency equals 1+ceil(shamt/STEP_BITS) for every case.

Source files
------------

// File: rtl/jedro_1_iter_shifter.sv
// jedro_1 iterative shift unit: SLL/SRL/SRA in STEP_BITS chunks per cycle.
// Valid/ready on both sides; result held in DONE until taken.
module jedro_1_iter_shifter #(
  parameter int DATA_WIDTH = 32,
  parameter int STEP_BITS  = 1,
  localparam int SHAMT_W   = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] operand_i,
  input  logic [SHAMT_W-1:0]    shamt_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  err_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_ILL = 2'b10;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            op_q, op_d;
  logic [SHAMT_W-1:0]    rem_q, rem_d;
  logic                  sign_q, sign_d;
  logic                  err_q, err_d;

  logic [SHAMT_W-1:0]    k;
  logic [DATA_WIDTH-1:0] sll_v, srl_v, sra_v;
  logic                  accept;

  assign in_ready_o  = (state_q == IDLE) && !rst_i;
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign result_o    = out_valid_o ? data_q : '0;
  assign err_o       = out_valid_o && err_q;

  // One iteration step: k = min(STEP_BITS, remaining), sign fill for SRA.
  always_comb begin
    if (int'(rem_q) < STEP_BITS) k = rem_q;
    else                         k = SHAMT_W'(STEP_BITS);
    sll_v = data_q << k;
    srl_v = data_q >> k;
    sra_v = srl_v;
    if (sign_q) sra_v = srl_v | ~({DATA_WIDTH{1'b1}} >> k);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    rem_d   = rem_q;
    sign_d  = sign_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = op_i;
          rem_d  = shamt_i;
          sign_d = operand_i[DATA_WIDTH-1];
          data_d = operand_i;
          err_d  = 1'b0;
          if (op_i == OP_ILL) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else if (shamt_i == '0) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        rem_d = rem_q - k;
        case (op_q)
          OP_SLL:  data_d = sll_v;
          OP_SRL:  data_d = srl_v;
          default: data_d = sra_v;
        endcase
        if (rem_d == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_jedro_1_iter_shifter.sv
// Bench for jedro_1_iter_shifter: several STEP_BITS instances,
// directed vector table, corner sequences and a model-based sweep.
module tb_jedro_1_iter_shifter;

  localparam int NI = 5;
  localparam int STEPS [NI] = '{1, 3, 4, 8, 32};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NI-1:0]   in_valid = '0;
  logic [NI-1:0]   in_ready;
  logic [1:0]      op = 2'b00;
  logic [31:0]     operand = '0;
  logic [4:0]      shamt = '0;
  logic [NI-1:0]   out_valid;
  logic            out_ready = 1'b1;
  logic [31:0]     result [NI];
  logic [NI-1:0]   err;
  logic [NI-1:0]   busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    jedro_1_iter_shifter #(
      .DATA_WIDTH(32),
      .STEP_BITS (STEPS[g])
    ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .in_valid_i (in_valid[g]),
      .in_ready_o (in_ready[g]),
      .op_i       (op),
      .operand_i  (operand),
      .shamt_i    (shamt),
      .out_valid_o(out_valid[g]),
      .out_ready_i(out_ready),
      .result_o   (result[g]),
      .err_o      (err[g]),
      .busy_o     (busy[g])
    );
  end

  typedef struct {
    int          idx;
    logic [1:0]  op;
    logic [31:0] x;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        err;
    int          lat;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(logic [1:0] o, logic [31:0] x,
                                        logic [4:0] s);
    case (o)
      2'b00:   return x << s;
      2'b01:   return x >> s;
      2'b11:   return $signed(x) >>> s;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int exp_lat(logic [1:0] o, logic [4:0] s, int st);
    if (o == 2'b10 || s == 0) return 1;
    return 1 + (int'(s) + st - 1) / st;
  endfunction

  // Issue one request and wait for its result; out_ready stays high.
  task automatic run(string nm, int idx, logic [1:0] o, logic [31:0] x,
                     logic [4:0] s, logic [31:0] er, logic ee, int el,
                     output logic [31:0] got);
    int lat;
    @(negedge clk);
    chk({nm, " in_ready"}, 32'(in_ready[idx]), 32'd1);
    op = o;
    operand = x;
    shamt = s;
    in_valid[idx] = 1'b1;
    @(negedge clk);
    in_valid[idx] = 1'b0;
    op = 2'b10;
    operand = 32'hA5A5_5A5A;
    shamt = 5'd17;
    lat = 1;
    while (!out_valid[idx] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    got = result[idx];
    chk({nm, " latency"}, 32'(lat), 32'(el));
    chk({nm, " result"}, result[idx], er);
    chk({nm, " err"}, 32'(err[idx]), 32'(ee));
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] x;
    int stale;

    repeat (2) @(negedge clk);
    chk("rst in_ready", 32'(in_ready[0]), 32'd0);
    chk("rst out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst busy", 32'(busy[0]), 32'd0);
    chk("rst result", result[0], 32'd0);
    chk("rst err", 32'(err[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", 32'(in_ready[0]), 32'd1);

    tbl.push_back('{0, 2'b00, 32'h1, 5'd6, 32'h0000_0040, 1'b0, 7});
    tbl.push_back('{2, 2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 9});
    tbl.push_back('{2, 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 9});
    tbl.push_back('{2, 2'b11, 32'h7000_0000, 5'd4, 32'h0700_0000, 1'b0, 2});
    tbl.push_back('{0, 2'b01, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0, 1});
    tbl.push_back('{0, 2'b10, 32'hFFFF_FFFF, 5'd5, 32'h0, 1'b1, 1});
    tbl.push_back('{1, 2'b00, 32'h1, 5'd31, 32'h8000_0000, 1'b0, 12});
    tbl.push_back('{4, 2'b11, 32'h8000_0000, 5'd1, 32'hC000_0000, 1'b0, 2});
    tbl.push_back('{3, 2'b01, 32'hF000_0000, 5'd9, 32'h0078_0000, 1'b0, 3});
    tbl.push_back('{4, 2'b00, 32'h1, 5'd31, 32'h8000_0000, 1'b0, 2});
    foreach (tbl[i])
      run($sformatf("vec%0d", i), tbl[i].idx, tbl[i].op, tbl[i].x,
          tbl[i].sh, tbl[i].res, tbl[i].err, tbl[i].lat, r);

    r = 32'd1;
    run("chain1", 0, 2'b00, r, 5'd1, 32'd2, 1'b0, 2, r);
    run("chain2", 0, 2'b00, r, 5'd2, 32'd8, 1'b0, 3, r);
    run("chain3", 0, 2'b00, r, 5'd3, 32'd64, 1'b0, 4, r);

    // Backpressure in DONE with a competing request.
    @(negedge clk);
    out_ready = 1'b0;
    op = 2'b00;
    operand = 32'd3;
    shamt = 5'd1;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("bp valid", 32'(out_valid[0]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = 1'b1;
      operand = 32'hAAAA_0000 + 32'(i);
      shamt = 5'd7;
      @(negedge clk);
      chk($sformatf("bp hold result %0d", i), result[0], 32'd6);
      chk($sformatf("bp in_ready %0d", i), 32'(in_ready[0]), 32'd0);
      chk($sformatf("bp valid %0d", i), 32'(out_valid[0]), 32'd1);
    end
    in_valid[0] = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release valid", 32'(out_valid[0]), 32'd0);
    chk("bp release in_ready", 32'(in_ready[0]), 32'd1);
    op = 2'b01;
    operand = 32'd5;
    shamt = 5'd0;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    chk("bp next accept valid", 32'(out_valid[0]), 32'd1);
    chk("bp next accept result", result[0], 32'd5);
    @(negedge clk);
    chk("bp next drained", 32'(out_valid[0]), 32'd0);

    // Reset while shifting.
    op = 2'b00;
    operand = 32'h1;
    shamt = 5'd20;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid busy", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid-rst valid", 32'(out_valid[0]), 32'd0);
    chk("mid-rst busy", 32'(busy[0]), 32'd0);
    chk("mid-rst result", result[0], 32'd0);
    chk("mid-rst in_ready", 32'(in_ready[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("after-rst in_ready", 32'(in_ready[0]), 32'd1);
    stale = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid[0]) stale++;
    end
    chk("no stale result", 32'(stale), 32'd0);

    // Model sweep across all instances.
    for (int d = 0; d < NI; d++) begin
      for (int o = 0; o < 4; o++) begin
        for (int s = 0; s < 32; s++) begin
          x = $urandom;
          run($sformatf("sw s%0d o%0d sh%0d x%h", STEPS[d], o, s, x),
              d, 2'(o), x, 5'(s), model(2'(o), x, 5'(s)),
              (o == 2), exp_lat(2'(o), 5'(s), STEPS[d]), r);
        end
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
